// File: rtl/ulx3s_input_conditioner.sv
// ulx3s_input_conditioner
//
// N-channel front end for raw board buttons and switches. Each channel is
// processed independently:
//    synchroniser -> debounce filter -> registered rise/fall pulses
//                                    -> toggle latch and saturating press counter
//
// Ports
//    clk_i     system clock; all state changes on its rising edge
//    reset_ni  asynchronous active-low reset
//    btn_i     raw asynchronous inputs, bit n = channel n
//    clear_i   synchronous clear of the toggle latches and press counters
//    level_o   debounced stable level per channel
//    rise_o    one-cycle pulse when level_o first shows a new 1
//    fall_o    one-cycle pulse when level_o first shows a new 0
//    toggle_o  inverts on every rise of its channel
//    count_o   saturating rise count; channel n in [n*CountWidth +: CountWidth]
module ulx3s_input_conditioner #(
    parameter int Channels       = 3,
    parameter int SyncStages     = 2,
    parameter int DebounceCycles = 250000,
    parameter int CountWidth     = 8
) (
    input  logic                           clk_i,
    input  logic                           reset_ni,
    input  logic [Channels-1:0]            btn_i,
    input  logic                           clear_i,
    output logic [Channels-1:0]            level_o,
    output logic [Channels-1:0]            rise_o,
    output logic [Channels-1:0]            fall_o,
    output logic [Channels-1:0]            toggle_o,
    output logic [Channels*CountWidth-1:0] count_o
);

    localparam int              DB_W      = $clog2(DebounceCycles + 1);
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DebounceCycles - 1);
    localparam logic [DB_W-1:0] DB_ONE    = DB_W'(1);
    localparam logic [CountWidth-1:0] PRESS_MAX = '1;
    localparam logic [CountWidth-1:0] PRESS_ONE = CountWidth'(1);

    for (genvar ch = 0; ch < Channels; ch++) begin : g_chan
        logic [SyncStages-1:0] sync_q;
        logic                  sync;
        logic [DB_W-1:0]       db_cnt_q;
        logic                  stable_q;
        logic                  rise_q;
        logic                  fall_q;
        logic                  toggle_q;
        logic [CountWidth-1:0] press_q;
        logic                  accept;
        logic                  rise_ev;

        assign sync = sync_q[SyncStages-1];

        // The new value is taken on the edge that would otherwise push the
        // counter to DebounceCycles, so a run of exactly DebounceCycles
        // differing samples is accepted.
        assign accept  = (sync != stable_q) && (db_cnt_q == DB_LAST);
        assign rise_ev = accept && sync;

        always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SyncStages-2:0], btn_i[ch]};
            end
        end

        always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                stable_q <= 1'b0;
                db_cnt_q <= '0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
            end else begin
                // Pulses are registered alongside stable_q so they line up
                // with the first cycle level_o shows the new value.
                rise_q <= rise_ev;
                fall_q <= accept && !sync;
                if (sync == stable_q) begin
                    db_cnt_q <= '0;
                end else if (accept) begin
                    stable_q <= sync;
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + DB_ONE;
                end
            end
        end

        // clear_i wins over a rise on the same edge; that rise is dropped.
        always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                toggle_q <= 1'b0;
                press_q  <= '0;
            end else if (clear_i) begin
                toggle_q <= 1'b0;
                press_q  <= '0;
            end else if (rise_ev) begin
                toggle_q <= ~toggle_q;
                if (press_q != PRESS_MAX) begin
                    press_q <= press_q + PRESS_ONE;
                end
            end
        end

        assign level_o[ch]  = stable_q;
        assign rise_o[ch]   = rise_q;
        assign fall_o[ch]   = fall_q;
        assign toggle_o[ch] = toggle_q;
        assign count_o[ch*CountWidth +: CountWidth] = press_q;
    end

endmodule

// File: tb/tb_ulx3s_input_conditioner.sv
// Testbench for ulx3s_input_conditioner (3 channels, 2 sync stages,
// debounce of 4 cycles, 4-bit counters). A reference model derives the
// debounced level from a short history window of raw input samples.
module tb_ulx3s_input_conditioner;

    localparam int CH = 3;
    localparam int SS = 2;
    localparam int DB = 4;
    localparam int CW = 4;
    localparam int HW = SS + DB;  // raw samples that influence the next level

    logic              clk;
    logic              rst_n;
    logic [CH-1:0]     btn;
    logic              clr;
    logic [CH-1:0]     level;
    logic [CH-1:0]     rise;
    logic [CH-1:0]     fall;
    logic [CH-1:0]     toggle;
    logic [CH*CW-1:0]  count;

    ulx3s_input_conditioner #(
        .Channels(CH), .SyncStages(SS), .DebounceCycles(DB), .CountWidth(CW)
    ) dut (
        .clk_i(clk), .reset_ni(rst_n), .btn_i(btn), .clear_i(clr),
        .level_o(level), .rise_o(rise), .fall_o(fall),
        .toggle_o(toggle), .count_o(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: hist[ch] bit i = raw input sampled i edges ago.
    // A new level is accepted when the DB samples that have reached the end
    // of the synchroniser all disagree with the current level.
    logic [HW-1:0] hist [CH];
    logic          m_lvl [CH];
    logic          m_rise[CH];
    logic          m_fall[CH];
    logic          m_tog [CH];
    int            m_cnt [CH];

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            hist[c] = '0; m_lvl[c] = 0; m_rise[c] = 0; m_fall[c] = 0;
            m_tog[c] = 0; m_cnt[c] = 0;
        end
    endtask

    task automatic model_edge(input logic [CH-1:0] b, input logic c_in);
        logic [DB-1:0] win;
        logic acc;
        for (int c = 0; c < CH; c++) begin
            hist[c] = {hist[c][HW-2:0], b[c]};
            win = hist[c][HW-1:SS];
            acc = m_lvl[c] ? (win == '0) : (win == '1);
            m_rise[c] = acc && !m_lvl[c];
            m_fall[c] = acc && m_lvl[c];
            if (acc) m_lvl[c] = !m_lvl[c];
            if (c_in) begin
                m_tog[c] = 0; m_cnt[c] = 0;
            end else if (m_rise[c]) begin
                m_tog[c] = !m_tog[c];
                if (m_cnt[c] < (1 << CW) - 1) m_cnt[c]++;
            end
        end
    endtask

    task automatic compare_all();
        logic [CH-1:0]    e_lvl, e_rise, e_fall, e_tog;
        logic [CH*CW-1:0] e_cnt;
        for (int c = 0; c < CH; c++) begin
            e_lvl[c] = m_lvl[c]; e_rise[c] = m_rise[c];
            e_fall[c] = m_fall[c]; e_tog[c] = m_tog[c];
            e_cnt[c*CW +: CW] = CW'(m_cnt[c]);
        end
        chk("level", 32'(level), 32'(e_lvl));
        chk("rise", 32'(rise), 32'(e_rise));
        chk("fall", 32'(fall), 32'(e_fall));
        chk("toggle", 32'(toggle), 32'(e_tog));
        chk("count", 32'(count), 32'(e_cnt));
    endtask

    // One clock: inputs are held across the edge, outputs checked 1ns later.
    task automatic cyc(input logic [CH-1:0] b, input logic c_in);
        btn = b;
        clr = c_in;
        @(posedge clk);
        #1;
        model_edge(b, c_in);
        compare_all();
    endtask

    // Reset asserted between edges; outputs must clear immediately.
    task automatic pulse_reset(input int edges);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        for (int i = 0; i < edges; i++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    int hold[CH];
    logic [CH-1:0] rb;
    int npulse;

    initial begin
        rst_n = 1'b0;
        btn   = 3'b111;
        clr   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        rst_n = 1'b1;

        // Input held high through reset shows up after edge 5.
        for (int i = 0; i < 8; i++) begin
            cyc(3'b111, 1'b0);
            if (i == 4) chk("rst_level_early", 32'(level), 32'h0);
            if (i == 5) begin
                chk("rst_rise6", 32'(rise), 32'h7);
                chk("rst_level6", 32'(level), 32'h7);
                chk("rst_count6", 32'(count), 32'h111);
                chk("rst_toggle6", 32'(toggle), 32'h7);
            end
        end

        // Glitch of 3 cycles is rejected, 4 cycles is accepted.
        for (int i = 0; i < 8; i++) cyc(3'b000, 1'b0);
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            cyc((i < 3) ? 3'b001 : 3'b000, 1'b0);
            npulse += int'(rise[0]);
        end
        chk("glitch_pulses", 32'(npulse), 32'h0);
        chk("glitch_count0", 32'(count[3:0]), 32'h1);
        for (int i = 0; i < 10; i++) begin
            cyc((i < 4) ? 3'b001 : 3'b000, 1'b0);
            if (i == 5) chk("glitch4_rise", 32'(rise[0]), 32'h1);
        end

        // Saturation: clear, then 20 clean presses on channel 1.
        cyc(3'b000, 1'b1);
        for (int p = 0; p < 20; p++) begin
            for (int i = 0; i < 6; i++) cyc(3'b010, 1'b0);
            for (int i = 0; i < 6; i++) cyc(3'b000, 1'b0);
        end
        chk("sat_count1", 32'(count[7:4]), 32'hF);
        chk("sat_toggle1", 32'(toggle[1]), 32'h0);

        // Clear on the same edge as a channel 2 rise.
        for (int i = 0; i < 8; i++) begin
            cyc(3'b100, i == 5);
            if (i == 5) begin
                chk("clr_rise2", 32'(rise[2]), 32'h1);
                chk("clr_toggle2", 32'(toggle[2]), 32'h0);
                chk("clr_count2", 32'(count[11:8]), 32'h0);
            end
        end

        // Concurrent fall on channel 0 and rise on channel 2.
        for (int i = 0; i < 8; i++) cyc(3'b001, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(3'b100, 1'b0);
            if (i == 5) begin
                chk("conc_fall0", 32'(fall[0]), 32'h1);
                chk("conc_rise2", 32'(rise[2]), 32'h1);
                chk("conc_ch1", 32'({rise[1], fall[1], level[1]}), 32'h0);
            end
        end

        // Reset in the middle of a channel 0 debounce.
        for (int i = 0; i < 3; i++) cyc(3'b101, 1'b0);
        pulse_reset(2);
        npulse = 0;
        for (int i = 0; i < 9; i++) begin
            cyc(3'b001, 1'b0);
            npulse += int'(rise[0]);
            if (i == 4) chk("mid_level_early", 32'(level[0]), 32'h0);
            if (i == 5) chk("mid_rise6", 32'(rise[0]), 32'h1);
        end
        chk("mid_pulses", 32'(npulse), 32'h1);

        // Randomised traffic with occasional clears and resets.
        for (int c = 0; c < CH; c++) hold[c] = 0;
        rb = '0;
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < CH; c++) begin
                if (hold[c] == 0) begin
                    rb[c]   = 1'($urandom_range(1, 0));
                    hold[c] = int'($urandom_range(8, 1));
                end
                hold[c]--;
            end
            if ($urandom_range(599, 0) == 0) pulse_reset(int'($urandom_range(3, 1)));
            cyc(rb, $urandom_range(19, 0) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ulx3s_input_conditioner.md
# ulx3s_input_conditioner

Parametrised N-channel input conditioner for the ULX3S board top. It generalises the fixed three-input, single-register front end into a configurable block. Each channel gets a metastability synchroniser, a debounce filter, edge pulses, a toggle latch and a saturating press counter. It sits between the raw board buttons/switches and the sorting accelerator control logic, and is driven by the same board-level simulation runner.

## Interface
- Channels, default 3: number of independent input channels (≥1).
- SyncStages, default 2: flip-flop stages in each synchroniser (≥2).
- DebounceCycles, default 250000: consecutive cycles a synchronised value must differ from the stable state before it is accepted (≥1).
- CountWidth, default 8: width of each per-channel rising-edge counter (≥1).
- clk_i, input, 1: system clock; all state is on its rising edge.
- reset_ni, input, 1: asynchronous, active-low reset.
- btn_i, input, Channels: raw asynchronous inputs, bit n = channel n.
- clear_i, input, 1: synchronous clear of the toggle latches and counters.
- level_o, output, Channels: debounced stable level.
- rise_o, output, Channels: one-cycle pulse on a debounced 0→1 transition.
- fall_o, output, Channels: one-cycle pulse on a debounced 1→0 transition.
- toggle_o, output, Channels: flips on every rise of its channel.
- count_o, output, Channels*CountWidth: rise count for each channel, channel n in bits [n*CountWidth +: CountWidth]; saturates.

## Operation
- Channels are fully independent; the per-channel datapath below is replicated.
- **Synchroniser:** shift register of SyncStages flops. sync = last stage.
- **Debounce state:** stable_q (drives level_o) and a counter of width $clog2(DebounceCycles+1).
- **Counter rule:**
  - sync == stable_q: counter ← 0.
  - sync != stable_q and counter == DebounceCycles-1: stable_q ← sync, counter ← 0.
  - Otherwise: counter increments.
  - DebounceCycles=1: stable_q follows sync with one register of delay.
- **Edge pulses:** rise_o/fall_o are registered and high in exactly the cycle in which level_o first shows the new value.
- **Toggle latch:** toggle_o inverts on each rise.
- **Press counter:** increments on each rise and holds at 2^CountWidth-1 (no wrap).
- **clear_i:** toggle_o ← 0 and counter ← 0 at the next edge.
  - clear_i has priority over a simultaneous rise; that rise is discarded for toggle and count.
  - rise_o/fall_o/level_o are unaffected.
  - clear_i is synchronous and is not synchronised internally.
- **Reset (reset_ni low), immediately:**
  - all synchroniser flops, stable_q and debounce counters ← 0;
  - level_o=0, rise_o=0, fall_o=0, toggle_o=0, count_o=0.
  - Asserting reset mid-debounce discards the partial count.
  - Deassertion: the first active edge is the first edge after reset_ni rises. An input held high through reset is reported as a normal rise after the full latency.

## Timing
- **Latency:** btn_i stable at a new value from before edge 0 → level_o and the matching rise_o/fall_o change after edge SyncStages+DebounceCycles-1.
  - With SyncStages=2, DebounceCycles=4: visible after edge 5, the 6th edge.
- toggle_o and count_o update on the same edge as rise_o.
- **Glitch rejection:** any excursion of sync shorter than DebounceCycles consecutive cycles leaves level_o unchanged and produces no pulse.
- **Pulse width:** pulses are exactly one cycle wide. Minimum spacing between opposite pulses on one channel is DebounceCycles cycles.
- **Simultaneous events:** different channels transitioning on the same edge all pulse on that edge.

## Test plan
All scenarios use Channels=3, SyncStages=2, DebounceCycles=4, CountWidth=4.
- **Reset:** hold reset_ni=0 with btn_i=3'b111 → all outputs 0. Release reset → level_o=3'b111 and rise_o=3'b111 for one cycle after the 6th edge; count_o channels = 1; toggle_o=3'b111.
- **Glitch:** btn_i[0]=1 for 3 cycles, then 0 → level_o[0] stays 0, no rise_o, count unchanged. The same stimulus held for 4+ cycles → rise after edge 5.
- **Saturation:** 20 clean presses on channel 1 → count_o[7:4]=4'hF; toggle_o[1]=0 (an even number of presses).
- **Clear priority:** assert clear_i on the same edge as a channel 2 rise → rise_o[2]=1, toggle_o[2]=0, count_o[11:8]=0.
- **Reset mid-debounce:** btn_i[0] goes high; pulse reset_ni low after 3 edges, then release → level_o[0] rises only 6 edges after release, with a single rise_o pulse.
- **Concurrent transitions:** channel 0 falls while channel 2 rises on the same cycle → fall_o[0] and rise_o[2] are asserted on the same edge; channel 1 outputs are unchanged.
